uwasic_onboarding_spi_pwm: RTL and testbench
============================================

// Module: uwasic_onboarding_spi_pwm
// PURPOSE
// Tiny Tapeout user top: an SPI-mode-0 write-only peripheral drives a 5-entry register file,
// which controls 16 outputs. Each output is forced low, forced high, or driven by a
// shared ~3 kHz 8-bit PWM. uo_out carries outputs 7:0; uio_out carries outputs 15:8.
// PARAMETERS
// CLK_DIV   13   system clocks per PWM counter tick (10 MHz/13/256 ~= 3.0 kHz PWM)
// NUM_REGS  5    valid register addresses 0x00..0x04
// PORTS
// clk      in   1  system clock, 10 MHz nominal
// rst_n    in   1  asynchronous active-low reset
// ena      in   1  design selected; ignored (logic always active)
// ui_in    in   8  [0]=SCLK, [1]=COPI, [2]=nCS; [7:3] unused
// uio_in   in   8  unused
// uo_out   out  8  outputs 7:0
// uio_out  out  8  outputs 15:8
// uio_oe   out  8  constant 8'hFF (all bidirectional pins are outputs)
// BEHAVIOUR
// Reset: all registers 0x00, PWM counter and prescaler 0, SPI shift state cleared;
//   uo_out = uio_out = 8'h00; uio_oe = 8'hFF at all times.
// Sync: SCLK, COPI and nCS each pass through a 2-FF synchronizer in clk; edges are detected
//   on the synchronized SCLK. SCLK must be <= clk/4.
// SPI frame, mode 0, MSB first, 16 bits while nCS is low:
//   bit15 = R/W (1 = write), bits14:8 = 7-bit address, bits7:0 = data.
//   COPI is sampled on the synchronized SCLK rising edge; a 5-bit counter tracks bits.
//   nCS falling clears the bit counter. Commit happens on nCS rising, and only if
//   exactly 16 bits were received and R/W = 1 and address <= 0x04. Otherwise the frame is dropped.
//   Extra or missing bits drop the frame. Reads return nothing; COPI is never driven out.
//   A register update is visible 1 clk after the commit cycle.
// Register map:
//   0x00 en_out[7:0]    0x01 en_out[15:8]
//   0x02 en_pwm[7:0]    0x03 en_pwm[15:8]
//   0x04 duty[7:0]
// PWM: the prescaler counts 0..CLK_DIV-1. At wrap, the 8-bit counter increments and wraps
//   from 255 to 0.
//   pwm = 1 if duty == 8'hFF; otherwise pwm = (counter < duty). duty = 0 gives constant low.
// Output bit i = en_out[i] ? (en_pwm[i] ? pwm : 1) : 0. The output is registered, one clk delay.
// Reset asserted mid-frame: the frame is lost and registers return to 0.
// nCS high during SCLK activity: edges are ignored.
// TESTING
// After reset: uo_out = 0x00, uio_out = 0x00, uio_oe = 0xFF.
// Write 0x00 <- 0xF0 -> uo_out = 0xF0. Write 0x01 <- 0xCC -> uio_out = 0xCC.
// Write 0x30 <- 0xAA (invalid address), and also a read frame (bit15 = 0) to 0x00
//   -> no register changes.
// en_out[0] = 1, en_pwm[0] = 1, duty = 0x80 -> uo_out[0] has period ~333 us (+/-1%)
//   and duty 50% (+/-1%).
// duty = 0x00 -> uo_out[0] constant 0. duty = 0xFF -> constant 1, with no edges over 1 ms.
// Frame aborted after 10 bits (nCS rises), then a full valid frame -> only the full
//   frame takes effect.

Source files
------------

// File: rtl/uwasic_onboarding_spi_pwm.sv
// SPI mode-0 write-only register file driving 16 outputs that can each be
// forced low, forced high, or follow a shared 8-bit PWM.
`timescale 1ns/1ps

module uwasic_onboarding_spi_pwm #(
    parameter int CLK_DIV  = 13,
    parameter int NUM_REGS = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [1:0]    r_sclk_sync, r_copi_sync, r_ncs_sync;
    logic          r_sclk_prev, r_ncs_prev;
    logic [4:0]    r_bit_cnt;
    logic [15:0]   r_shift;
    logic [15:0]   r_en_out, r_en_pwm;
    logic [7:0]    r_duty;
    logic [PW-1:0] r_presc;
    logic [7:0]    r_pwm_cnt;
    logic [15:0]   r_out;

    logic          w_sclk_rise, w_ncs_fall, w_ncs_rise, w_commit, w_pwm;
    logic [15:0]   w_out_next;
    logic          w_unused;

    assign w_unused = &{1'b0, ena, uio_in, ui_in[7:3]};

    // nCS synchronizer idles high so that leaving reset never looks like a frame end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync <= 2'b00;
            r_copi_sync <= 2'b00;
            r_ncs_sync  <= 2'b11;
            r_sclk_prev <= 1'b0;
            r_ncs_prev  <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling the pre-edge value.
            r_sclk_sync <= {r_sclk_sync[0], ui_in[0]};
            r_copi_sync <= {r_copi_sync[0], ui_in[1]};
            r_ncs_sync  <= {r_ncs_sync[0], ui_in[2]};
            r_sclk_prev <= r_sclk_sync[1];
            r_ncs_prev  <= r_ncs_sync[1];
        end
    end

    assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_prev & ~r_ncs_sync[1];
    assign w_ncs_fall  = ~r_ncs_sync[1] & r_ncs_prev;
    assign w_ncs_rise  = r_ncs_sync[1] & ~r_ncs_prev;
    assign w_commit    = w_ncs_rise && (r_bit_cnt == 5'd16) && r_shift[15]
                         && (r_shift[14:8] < 7'(NUM_REGS));

    // Bit counter saturates so that very long frames cannot wrap back to 16.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt <= 5'd0;
            r_shift   <= 16'h0000;
        end else if (w_ncs_fall) begin
            r_bit_cnt <= 5'd0;
        end else if (w_sclk_rise) begin
            r_shift <= {r_shift[14:0], r_copi_sync[1]};
            if (r_bit_cnt != 5'd31) r_bit_cnt <= r_bit_cnt + 5'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en_out <= 16'h0000;
            r_en_pwm <= 16'h0000;
            r_duty   <= 8'h00;
        end else if (w_commit) begin
            case (r_shift[10:8])
                3'd0:    r_en_out[7:0]  <= r_shift[7:0];
                3'd1:    r_en_out[15:8] <= r_shift[7:0];
                3'd2:    r_en_pwm[7:0]  <= r_shift[7:0];
                3'd3:    r_en_pwm[15:8] <= r_shift[7:0];
                3'd4:    r_duty         <= r_shift[7:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc   <= '0;
            r_pwm_cnt <= 8'h00;
        end else if (r_presc == PW'(CLK_DIV - 1)) begin
            r_presc   <= '0;
            r_pwm_cnt <= r_pwm_cnt + 8'h01;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    assign w_pwm = (r_duty == 8'hFF) || (r_pwm_cnt < r_duty);

    always_comb begin
        // NOTE: the default assignment first guarantees no latch is inferred.
        w_out_next = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            if (r_en_out[i]) w_out_next[i] = r_en_pwm[i] ? w_pwm : 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_out <= 16'h0000;
        else        r_out <= w_out_next;
    end

    assign uo_out  = r_out[7:0];
    assign uio_out = r_out[15:8];
    assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_uwasic_onboarding_spi_pwm.sv
// Bench for uwasic_onboarding_spi_pwm: SPI frames are driven directly,
// expected pin states are queued and compared by an independent monitor.
`timescale 1ns/1ps

module tb_uwasic_onboarding_spi_pwm;

    typedef struct {
        string       name;
        logic [23:0] exp;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk = 1'b0, copi = 1'b0, ncs = 1'b1;
    logic [7:0] ui_in, uio_in;
    logic [7:0] uo_out, uio_out, uio_oe;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    assign ui_in  = {5'b00000, ncs, copi, sclk};
    assign uio_in = 8'h00;

    always #50 clk = ~clk;

    uwasic_onboarding_spi_pwm dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (1'b1),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pins are sampled on the falling edge, away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check(e.name, {8'h00, uio_oe, uio_out, uo_out}, {8'h00, e.exp});
            end
        end
    end

    task automatic expect_out(input string name, input logic [15:0] outs);
        int t = 0;
        exp_q.push_back('{name, {8'hFF, outs}});
        while (exp_q.size() != 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL %s: scoreboard not drained, got %0d entries, expected 0", name, exp_q.size());
        end
    endtask

    task automatic spi_bits(input logic [31:0] bits, input int n);
        ncs = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = n - 1; i >= 0; i--) begin
            copi = bits[i];
            repeat (4) @(negedge clk);
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (4) @(negedge clk);
        ncs = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic spi_write(input logic [6:0] addr, input logic [7:0] data);
        spi_bits({16'h0000, 1'b1, addr, data}, 16);
    endtask

    task automatic measure_pwm(output int hi, output int lo);
        int t;
        hi = 0;
        lo = 0;
        t  = 0;
        while (uo_out[0] !== 1'b0 && t < 8000) begin @(negedge clk); t++; end
        t = 0;
        while (uo_out[0] !== 1'b1 && t < 8000) begin @(negedge clk); t++; end
        while (uo_out[0] === 1'b1 && hi < 8000) begin @(negedge clk); hi++; end
        while (uo_out[0] === 1'b0 && lo < 8000) begin @(negedge clk); lo++; end
    endtask

    initial begin
        #30ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi, lo, ones, zeros, edges;
        logic prev;

        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        expect_out("after_reset", 16'h0000);

        spi_write(7'h00, 8'hF0);
        expect_out("write_r0_f0", 16'h00F0);
        spi_write(7'h01, 8'hCC);
        expect_out("write_r1_cc", 16'hCCF0);

        spi_write(7'h30, 8'hAA);
        expect_out("bad_addr_30", 16'hCCF0);
        spi_write(7'h05, 8'hAA);
        expect_out("bad_addr_05", 16'hCCF0);
        spi_bits(32'h0000_0055, 16);
        expect_out("read_frame_ignored", 16'hCCF0);

        spi_bits(32'h0000_8055 >> 6, 10);
        expect_out("aborted_10_bits", 16'hCCF0);
        spi_write(7'h00, 8'h0F);
        expect_out("full_after_abort", 16'hCC0F);
        spi_bits({15'h0000, 16'h8033, 1'b0}, 17);
        expect_out("frame_17_bits", 16'hCC0F);

        spi_write(7'h01, 8'h00);
        spi_write(7'h00, 8'h01);
        spi_write(7'h02, 8'h01);
        spi_write(7'h04, 8'h80);
        measure_pwm(hi, lo);
        check("pwm80_high_clks", hi, 1664);
        check("pwm80_period_clks", hi + lo, 3328);
        check("pwm80_other_pins", {uio_out, uo_out[7:1]}, 0);

        spi_write(7'h04, 8'h00);
        ones = 0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (uo_out[0] === 1'b1) ones++;
        end
        check("duty00_high_clks", ones, 0);

        spi_write(7'h04, 8'hFF);
        zeros = 0;
        edges = 0;
        prev  = uo_out[0];
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (uo_out[0] !== 1'b1) zeros++;
            if (uo_out[0] !== prev) edges++;
            prev = uo_out[0];
        end
        check("dutyff_low_clks", zeros, 0);
        check("dutyff_edges", edges, 0);

        spi_write(7'h01, 8'h01);
        spi_write(7'h03, 8'h01);
        expect_out("pwm_upper_bank", 16'h0101);
        spi_write(7'h00, 8'h00);
        expect_out("en_out_gates_pwm", 16'h0100);

        ncs = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            copi = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
        rst_n = 1'b0;
        ncs   = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        expect_out("reset_mid_frame", 16'h0000);
        spi_write(7'h00, 8'h3C);
        expect_out("write_after_reset", 16'h003C);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
